signal_safety_monitor: RTL
==========================

# signal_safety_monitor

Conflict monitor and lamp-drive stage sitting directly downstream of the four-way traffic sequencer. Samples the sequencer's four 2-bit approach codes every clock, checks them for illegal codes, conflicting greens, forbidden transitions and, optionally, a stalled sequencer. Clean input is passed to the lamp outputs with one cycle of latency. On any violation it latches a fault and overrides all lamps with a flashing-yellow failsafe until cleared.

## Interface
- FLASH_DIV, default 25000000: clock cycles per flash half-period in failsafe; must be ≥ 2.
- STUCK_CYCLES, default 300000000: cycles of unchanged input that count as a stalled sequencer; must be ≥ 2. Used only with the stall check compiled in.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- north  input  2  approach code: 00 red, 01 yellow, 10 green, 11 illegal. east, south and west use the same width and encoding.
- clear  input  1  level, sampled each cycle; requests exit from failsafe.
- lamp_out  output  8  registered lamp drive {north, east, south, west}, same encoding as the inputs.
- fault  output  1  registered; high while in failsafe.
- fault_code  output  3  registered; 0 none, 1 illegal code, 2 multiple greens, 3 green→red, 4 stalled.

## Operation
- Internal registers:
  - state: INIT, RUN or FLASH.
  - prev[7:0]: the last accepted input word.
  - flash counter, 32-bit, plus a phase bit.
  - stall counter, 32-bit.
- Combinational checks, evaluated on the port values each cycle, in priority order:
  - code 1: any approach equals 11.
  - code 2: more than one approach equals 10.
  - code 3: any approach is 00 where its prev value is 10. Evaluated only in RUN.
  - code 4: stall counter equals STUCK_CYCLES-1 and input equals prev. Evaluated only in RUN.
- Allowed per-approach transitions: red→green, red→yellow, yellow→red, yellow→green, green→yellow, and any code held unchanged.
- INIT:
  - If code 1 or 2 fires, go to FLASH.
  - Otherwise load prev and lamp_out with the input, clear the stall counter, and go to RUN.
- RUN:
  - If any check fires, go to FLASH and latch fault=1 and fault_code with the highest-priority code.
  - Otherwise load prev and lamp_out with the input. The stall counter clears when the input differs from prev, else increments.
  - clear is ignored.
- FLASH:
  - Entry: flash counter=0, phase=1, lamp_out=8'h55 (all yellow).
  - Each cycle the counter increments. At FLASH_DIV-1 it wraps to 0 and phase toggles.
  - lamp_out = 8'h55 when phase=1, 8'h00 (all red) when phase=0.
  - fault and fault_code are held.
  - Further violations do not change fault_code.
- Exit from FLASH: requires clear=1 with codes 1 and 2 both false on the current input. Then go to INIT, with fault=0, fault_code=0 and lamp_out=8'h00.
- clear=1 while the input is still illegal: stay in FLASH.

## Timing
- Reset values (asynchronous):
  - state INIT, lamp_out 8'h00, fault 0, fault_code 0.
  - prev 8'h00, counters 0, phase 1.
- Pass-through latency: 1 cycle. An input present at edge k appears on lamp_out after edge k.
- Fault latency: 1 cycle. At the edge where the offending input is sampled, fault, fault_code and lamp_out=8'h55 all update together. An illegal or conflicting input never reaches lamp_out.
- Flash period: 2·FLASH_DIV cycles. The first half-period after entry is yellow.
- Clear: exit takes 1 cycle to INIT. Normal pass-through resumes 1 cycle later, so lamp_out holds 8'h00 for exactly 1 cycle.
- Reset mid-failsafe: immediate return to INIT with all outputs at their reset values; no fault memory survives reset.
- Counters never overflow. The flash counter wraps at FLASH_DIV-1; the stall counter faults at STUCK_CYCLES-1.

## Configuration
- Macro: SAFETY_STALL_CHECK_EN.
- Defined: the stall counter and check code 4 are built.
- Undefined:
  - No stall counter is built.
  - Check code 4 never fires.
  - STUCK_CYCLES is ignored.
  - All other behaviour is identical.

## Test plan
All scenarios run with FLASH_DIV=4 and STUCK_CYCLES=10.
- Reset then the legal sequence 55→80→50→20→14→08→05→02→41→80, each word held 3 cycles:
  - lamp_out follows each word 1 cycle later.
  - fault stays 0.
- From a RUN input of 80 (north green), drive 08 (north red directly):
  - Next edge: fault=1, fault_code=3, lamp_out=55.
  - lamp_out then alternates 55 for 4 cycles and 00 for 4 cycles.
- Drive A0 (north and east green) in RUN: next edge gives fault_code=2, and lamp_out never shows A0. Same check with C0: fault_code=1, since code 1 outranks code 2.
- In FLASH, assert clear while the input is A0: state stays FLASH. Change the input to 00 with clear still high:
  - Next edge: fault=0, fault_code=0, lamp_out=00.
  - One edge later lamp_out=00 via pass-through. Then drive 80: lamp_out=80 one cycle later, with no code-3 fault.
- With SAFETY_STALL_CHECK_EN defined, hold 80 in RUN: fault_code=4 on the 10th cycle after the last change. With the macro undefined, hold 80 for 1000 cycles: fault stays 0.
- Assert rst_n low mid-FLASH during the 00 phase: outputs return to 00, 0 and 0 asynchronously. After release, legal input passes through normally.

Source files
------------

// File: rtl/signal_safety_monitor.sv
// Conflict monitor and lamp-drive stage for a four-way traffic sequencer; latches faults into flashing-yellow failsafe.
// Optional stalled-sequencer check is built when SAFETY_STALL_CHECK_EN is defined.
module signal_safety_monitor #(
  parameter int unsigned FLASH_DIV    = 25000000,
  parameter int unsigned STUCK_CYCLES = 300000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] north,
  input  logic [1:0] east,
  input  logic [1:0] south,
  input  logic [1:0] west,
  input  logic       clear,
  output logic [7:0] lamp_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLASH} state_t;

  localparam logic [31:0] FLASH_LAST = 32'(FLASH_DIV - 1);
  localparam logic [7:0]  ALL_YELLOW = 8'h55;
  localparam logic [7:0]  ALL_RED    = 8'h00;

  state_t      state_reg, state_next;
  logic [7:0]  prev_reg, prev_next;
  logic [7:0]  lamp_reg, lamp_next;
  logic        fault_reg, fault_next;
  logic [2:0]  code_reg, code_next;
  logic [31:0] flash_cnt_reg, flash_cnt_next;
  logic        phase_reg, phase_next;

  logic [7:0] word;
  logic [3:0] is_illegal, is_green, green_to_red;
  logic       chk_illegal, chk_multi, chk_g2r, chk_stall, any_fault;
  logic [2:0] code_sel;

  assign word = {north, east, south, west};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_approach
      assign is_illegal[gi]   = (word[2*gi +: 2] == 2'b11);
      assign is_green[gi]     = (word[2*gi +: 2] == 2'b10);
      assign green_to_red[gi] = (prev_reg[2*gi +: 2] == 2'b10) && (word[2*gi +: 2] == 2'b00);
    end
  endgenerate

  assign chk_illegal = |is_illegal;
  assign chk_multi   = ($countones(is_green) > 1);
  assign chk_g2r     = (state_reg == ST_RUN) && (|green_to_red);

`ifdef SAFETY_STALL_CHECK_EN
  localparam logic [31:0] STUCK_LAST = 32'(STUCK_CYCLES - 1);

  logic [31:0] stall_reg, stall_next;

  assign chk_stall = (state_reg == ST_RUN) && (stall_reg == STUCK_LAST) && (word == prev_reg);

  // Counts consecutive accepted cycles with an unchanged input word.
  always_comb begin
    stall_next = stall_reg;
    if (state_reg == ST_INIT) begin
      stall_next = '0;
    end else if (state_reg == ST_RUN && !any_fault) begin
      stall_next = (word != prev_reg) ? 32'd0 : stall_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_reg <= '0;
    end else begin
      stall_reg <= stall_next;
    end
  end
`else
  assign chk_stall = 1'b0;
`endif

  assign any_fault = chk_illegal | chk_multi | chk_g2r | chk_stall;

  always_comb begin
    code_sel = 3'd0;
    if (chk_illegal)    code_sel = 3'd1;
    else if (chk_multi) code_sel = 3'd2;
    else if (chk_g2r)   code_sel = 3'd3;
    else if (chk_stall) code_sel = 3'd4;
  end

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    lamp_next      = lamp_reg;
    fault_next     = fault_reg;
    code_next      = code_reg;
    flash_cnt_next = flash_cnt_reg;
    phase_next     = phase_reg;
    case (state_reg)
      ST_INIT, ST_RUN: begin
        // Sequence checks are gated to RUN inside chk_g2r/chk_stall, so INIT sees only codes 1 and 2.
        if (any_fault) begin
          state_next     = ST_FLASH;
          fault_next     = 1'b1;
          code_next      = code_sel;
          flash_cnt_next = '0;
          phase_next     = 1'b1;
          lamp_next      = ALL_YELLOW;
        end else begin
          state_next = ST_RUN;
          prev_next  = word;
          lamp_next  = word;
        end
      end
      ST_FLASH: begin
        if (clear && !chk_illegal && !chk_multi) begin
          state_next = ST_INIT;
          fault_next = 1'b0;
          code_next  = 3'd0;
          lamp_next  = ALL_RED;
        end else begin
          if (flash_cnt_reg == FLASH_LAST) begin
            flash_cnt_next = '0;
            phase_next     = ~phase_reg;
          end else begin
            flash_cnt_next = flash_cnt_reg + 32'd1;
          end
          lamp_next = phase_next ? ALL_YELLOW : ALL_RED;
        end
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      prev_reg      <= '0;
      lamp_reg      <= '0;
      fault_reg     <= 1'b0;
      code_reg      <= 3'd0;
      flash_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      lamp_reg      <= lamp_next;
      fault_reg     <= fault_next;
      code_reg      <= code_next;
      flash_cnt_reg <= flash_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  assign lamp_out   = lamp_reg;
  assign fault      = fault_reg;
  assign fault_code = code_reg;

endmodule
